// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO poll master: FSM states, slave data
// register address and timeout counter sizing.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EVAL
  } poll_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Counter must be able to hold TIMEOUT itself, where it saturates.
  function automatic int tmo_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pio_poll_if.sv
// Avalon-MM read-only bus between the poll master and a PIO slave.
interface pio_poll_if;
  logic [1:0]  address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (output address, read, input waitrequest, readdata);
  modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/pio_poll_debounce.sv
// Debouncer: a value is published once STABLE_CNT consecutive samples agree,
// with a one-cycle change pulse and the XOR mask against the previous value.
module poll_debounce #(
  parameter int DATA_W     = 10,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_en,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              change_pulse,
  output logic [DATA_W-1:0] changed_bits
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [DATA_W-1:0] chg_q, chg_d;
  logic [3:0]        stable_q, stable_d;
  logic              valid_q, valid_d;
  logic              pulse_q, pulse_d;

  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    value_d  = value_q;
    chg_d    = chg_q;
    valid_d  = valid_q;
    pulse_d  = 1'b0;
    if (sample_en) begin
      if (sample == cand_q) begin
        if (stable_q < STABLE_MAX) stable_d = stable_q + 4'd1;
      end else begin
        cand_d   = sample;
        stable_d = 4'd1;
      end
      // The very first acceptance pulses even when the value equals reset 0.
      if (stable_d == STABLE_MAX && (cand_d != value_q || !valid_q)) begin
        value_d = cand_d;
        chg_d   = cand_d ^ value_q;
        valid_d = 1'b1;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      stable_q <= '0;
      value_q  <= '0;
      chg_q    <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      value_q  <= value_d;
      chg_q    <= chg_d;
      valid_q  <= valid_d;
      pulse_q  <= pulse_d;
    end
  end

  assign value        = value_q;
  assign value_valid  = valid_q;
  assign change_pulse = pulse_q;
  assign changed_bits = chg_q;

endmodule

// File: rtl/pio_poll_master.sv
// Periodic Avalon-MM poller of a PIO data register with debounced output.
// Define PIO_POLL_IRQ_EN to add a level irq output with an irq_ack input.
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int DATA_W       = 10,
  parameter int POLL_DIV     = 50000,
  parameter int READ_LATENCY = 1,
  parameter int STABLE_CNT   = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  pio_poll_if.master        avm,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              change_pulse,
  output logic [DATA_W-1:0] changed_bits,
  output logic              timeout_err
`ifdef PIO_POLL_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_ack
`endif
);

  localparam int DIV_W = $clog2(POLL_DIV);
  localparam int TMO_W = tmo_cnt_w(TIMEOUT);

  poll_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        lat_q, lat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              read_q, read_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              tick;

  assign tick = enable && (div_q == DIV_W'(POLL_DIV - 1));

  always_comb begin
    div_d    = enable ? (tick ? '0 : div_q + DIV_W'(1)) : '0;
    state_d  = state_q;
    read_d   = read_q;
    lat_d    = lat_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    sample_d = sample_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = REQ;
        read_d  = 1'b1;
      end
      REQ: if (!avm.waitrequest) begin
        state_d = WAIT_DATA;
        read_d  = 1'b0;
        lat_d   = 3'(READ_LATENCY);
        tmo_d   = '0;
        if (!enable) err_d = 1'b0;
      end else begin
        // read is never withdrawn; a stalled slave only raises the flag
        if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
        if (tmo_d == TMO_W'(TIMEOUT)) err_d = 1'b1;
      end
      WAIT_DATA: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          sample_d = avm.readdata[DATA_W-1:0];
          state_d  = EVAL;
        end
      end
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      lat_q    <= '0;
      tmo_q    <= '0;
      read_q   <= 1'b0;
      err_q    <= 1'b0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      lat_q    <= lat_d;
      tmo_q    <= tmo_d;
      read_q   <= read_d;
      err_q    <= err_d;
      sample_q <= sample_d;
    end
  end

  assign avm.address = PIO_DATA_ADDR;
  assign avm.read    = read_q;
  assign timeout_err = err_q;

  if (DATA_W < 32) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^avm.readdata[31:DATA_W];
  end

  poll_debounce #(
    .DATA_W     (DATA_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample_q),
    .sample_en    (state_q == EVAL),
    .value        (value),
    .value_valid  (value_valid),
    .change_pulse (change_pulse),
    .changed_bits (changed_bits)
  );

`ifdef PIO_POLL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (change_pulse) irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master: transaction-level reference model checked
// every cycle, plus literal expectations at the end of each scenario.
module tb_pio_poll_master;

  localparam int DW  = 10;
  localparam int DIV = 8;
  localparam int LAT = 3;
  localparam int STB = 2;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          wr = 1'b0;
  logic          ack = 1'b0;
  logic [DW-1:0] sw = '0;
  int            pend = -1;

  logic [DW-1:0] value, changed_bits;
  logic          value_valid, change_pulse, timeout_err;
`ifdef PIO_POLL_IRQ_EN
  logic          irq;
`endif

  pio_poll_if bus ();

  // Only the cycle LAT after the accept carries the switch value; every other
  // cycle shows the complement so a mistimed sample is visible.
  assign bus.waitrequest = wr;
  assign bus.readdata    = (pend == 0) ? {22'h2AB5C3, sw} : {22'h1F0F0F, ~sw};

  pio_poll_master #(
    .DATA_W(DW), .POLL_DIV(DIV), .READ_LATENCY(LAT), .STABLE_CNT(STB), .TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .enable       (en),
    .avm          (bus),
    .value        (value),
    .value_valid  (value_valid),
    .change_pulse (change_pulse),
    .changed_bits (changed_bits),
    .timeout_err  (timeout_err)
`ifdef PIO_POLL_IRQ_EN
    ,
    .irq          (irq),
    .irq_ack      (ack)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int npulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) pend = -1;
    else begin
      if (pend >= 0) pend--;
      if (bus.read && !bus.waitrequest) pend = LAT;
    end
  end

  // Reference model: transaction phases plus a sample history for debounce.
  int            m_div = 0, m_wait = 0, m_stall = 0, m_run;
  bit            m_req = 0, m_eval = 0, m_vv = 0, m_pulse = 0, m_err = 0, m_irq = 0, m_tick;
  logic [DW-1:0] m_val = '0, m_chg = '0, m_samp = '0;
  logic [DW-1:0] hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div = 0; m_wait = 0; m_stall = 0; m_req = 0; m_eval = 0; m_vv = 0;
      m_pulse = 0; m_err = 0; m_irq = 0; m_val = '0; m_chg = '0; m_samp = '0;
      hist.delete();
    end else begin
      if (m_pulse) m_irq = 1;
      else if (ack) m_irq = 0;
      m_tick = en && (m_div == DIV - 1);
      m_div  = en ? (m_div + 1) % DIV : 0;
      m_pulse = 0;
      if (m_eval) begin
        m_eval = 0;
        hist.push_back(m_samp);
        if (hist.size() > 16) void'(hist.pop_front());
        m_run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i] != m_samp) break;
          m_run++;
        end
        if (m_run >= STB && (m_samp != m_val || !m_vv)) begin
          m_chg = m_samp ^ m_val; m_val = m_samp; m_vv = 1; m_pulse = 1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_samp = sw; m_eval = 1; end
      end else if (m_req) begin
        if (wr) begin
          m_stall++;
          if (m_stall >= TMO) m_err = 1;
        end else begin
          m_req = 0; m_wait = LAT; m_stall = 0;
          if (!en) m_err = 0;
        end
      end else if (m_tick) m_req = 1;
    end
  end

  always @(negedge clk) begin
    if (change_pulse) npulse++;
    chk("avm_read", {31'd0, bus.read}, {31'd0, m_req});
    chk("avm_address", {30'd0, bus.address}, 32'd0);
    chk("value", {22'd0, value}, {22'd0, m_val});
    chk("value_valid", {31'd0, value_valid}, {31'd0, m_vv});
    chk("change_pulse", {31'd0, change_pulse}, {31'd0, m_pulse});
    chk("changed_bits", {22'd0, changed_bits}, {22'd0, m_chg});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
`ifdef PIO_POLL_IRQ_EN
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_read(input logic lvl);
    int k = 0;
    while (bus.read !== lvl && k < 40) begin cyc(1); k++; end
    chk("wait_read_bound", {31'd0, bus.read}, {31'd0, lvl});
  endtask

  initial begin
    #1 rst = 1'b1;
    cyc(3);
    chk("rst_value", {22'd0, value}, 32'd0);
    chk("rst_read", {31'd0, bus.read}, 32'd0);
    chk("rst_valid", {31'd0, value_valid}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;

    // first acceptance after two agreeing polls, then silence
    sw = 10'h2A5; en = 1'b1;
    cyc(56);
    chk("s1_value", {22'd0, value}, 32'h2A5);
    chk("s1_changed", {22'd0, changed_bits}, 32'h2A5);
    chk("s1_valid", {31'd0, value_valid}, 32'd1);
    chk("s1_pulses", npulse, 1);

    // single-poll glitch is filtered
    wait_read(1'b0); wait_read(1'b1);
    sw = 10'h000;
    cyc(6);
    sw = 10'h2A5;
    cyc(32);
    chk("s2_value", {22'd0, value}, 32'h2A5);
    chk("s2_pulses", npulse, 1);

    // a real change of bit 9
    sw = 10'h0A5;
    cyc(40);
    chk("s3_value", {22'd0, value}, 32'h0A5);
    chk("s3_changed", {22'd0, changed_bits}, 32'h200);
    chk("s3_pulses", npulse, 2);

    // slave stalls 20 cycles: flag rises after the 16th stalled cycle
    wait_read(1'b0);
    wr = 1'b1;
    wait_read(1'b1);
    cyc(15);
    chk("s4_err_before", {31'd0, timeout_err}, 32'd0);
    cyc(1);
    chk("s4_err_at", {31'd0, timeout_err}, 32'd1);
    chk("s4_read_held", {31'd0, bus.read}, 32'd1);
    cyc(4);
    wr = 1'b0;
    cyc(1);
    chk("s4_read_done", {31'd0, bus.read}, 32'd0);
    cyc(12);
    chk("s4_err_sticky", {31'd0, timeout_err}, 32'd1);

    // enable drops mid-transaction: the pending read still completes and is used
    wait_read(1'b0); wait_read(1'b1);
    sw = 10'h155;
    cyc(1);
    wr = 1'b1;
    wait_read(1'b0); wait_read(1'b1);
    cyc(2);
    en = 1'b0;
    cyc(2);
    wr = 1'b0;
    cyc(1);
    chk("s5_err_clear", {31'd0, timeout_err}, 32'd0);
    cyc(20);
    chk("s5_value", {22'd0, value}, 32'h155);
    chk("s5_changed", {22'd0, changed_bits}, 32'h1F0);
    chk("s5_pulses", npulse, 3);
    chk("s5_idle", {31'd0, bus.read}, 32'd0);

    // asynchronous reset in the middle of a stalled request
    en = 1'b1; wr = 1'b1;
    wait_read(1'b1);
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("s6_read", {31'd0, bus.read}, 32'd0);
    chk("s6_value", {22'd0, value}, 32'd0);
    chk("s6_valid", {31'd0, value_valid}, 32'd0);
    chk("s6_changed", {22'd0, changed_bits}, 32'd0);
    chk("s6_err", {31'd0, timeout_err}, 32'd0);
    wr = 1'b0;
    cyc(2);
    rst = 1'b0;

`ifdef PIO_POLL_IRQ_EN
    sw = 10'h00F; en = 1'b1;
    cyc(40);
    chk("irq_set", {31'd0, irq}, 32'd1);
    ack = 1'b1; cyc(1); ack = 1'b0;
    chk("irq_ack", {31'd0, irq}, 32'd0);
    sw = 10'h0F0;
    begin
      int k = 0;
      while (!change_pulse && k < 60) begin cyc(1); k++; end
      chk("irq_pulse_bound", {31'd0, change_pulse}, 32'd1);
    end
    ack = 1'b1; cyc(1); ack = 1'b0;
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
`endif

    cyc(4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
